// File: rtl/dmem_map_pkg.sv
// Shared address-map constants and types for the
// data-memory responder and its MMIO block.
package dmem_map_pkg;

  localparam logic [1:0] OFF_CYCLE  = 2'd0;
  localparam logic [1:0] OFF_TX     = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;

  localparam int ST_EMPTY     = 1;
  localparam int ST_FULL      = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_BERR      = 4;
  localparam int ST_COUNT_LSB = 5;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_MMIO,
    REG_UNMAPPED
  } region_e;

  function automatic logic [31:0] status_word(
    input logic [5:0] cnt,
    input logic       berr,
    input logic       ovf,
    input logic       full,
    input logic       empty
  );
    status_word = {21'b0, cnt, berr, ovf,
                   full, empty, 1'b0};
  endfunction

endpackage

// File: rtl/dmem_responder_tx_fifo.sv
// Synchronous console TX FIFO; a push into a full
// FIFO is accepted only when a pop frees a slot.
module tx_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_din,
  input  logic          i_pop,
  output logic [W-1:0]  o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_pop;
  logic          w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
  assign o_dout  = o_empty ? '0 : r_mem[r_rd];

  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop)
        r_count <= r_count + 1'b1;
      else if (w_pop && !w_push)
        r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory port target: word RAM, cycle counter,
// status register and console TX FIFO.
module dmem_responder
  import dmem_map_pkg::*;
#(
  parameter int          RAM_AW     = 12,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'h0000_1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        bus_err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0] r_ram [2**RAM_AW];
  logic [31:0] r_q;
  logic [31:0] r_cycle;
  logic        r_ovf;
  logic        r_berr;

  logic [31:0]   w_off;
  region_e       w_region;
  logic          w_cyc_hit;
  logic          w_tx_hit;
  logic          w_st_hit;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [31:0]   w_status;
  logic [31:0]   w_rdata;

  assign w_off = address_dmem - MMIO_BASE;

  always_comb begin
    w_region = REG_UNMAPPED;
    if ((address_dmem >> RAM_AW) == '0)
      w_region = REG_RAM;
    else if (address_dmem >= MMIO_BASE
             && w_off < 32'd3)
      w_region = REG_MMIO;
  end

  assign w_cyc_hit = (w_region == REG_MMIO)
                  && (w_off[1:0] == OFF_CYCLE);
  assign w_tx_hit  = (w_region == REG_MMIO)
                  && (w_off[1:0] == OFF_TX);
  assign w_st_hit  = (w_region == REG_MMIO)
                  && (w_off[1:0] == OFF_STATUS);

  assign tx_valid = !w_empty;
  assign w_pop    = tx_valid && tx_ready;
  assign w_push   = wren && w_tx_hit;
  assign w_drop   = w_push && w_full && !w_pop;

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8),
    .CW    (CW)
  ) u_fifo (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_push  (w_push),
    .i_din   (data[7:0]),
    .i_pop   (w_pop),
    .o_dout  (tx_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_status = status_word(6'(w_count),
                                r_berr, r_ovf,
                                w_full, w_empty);

  always_comb begin
    w_rdata = '0;
    unique case (1'b1)
      w_region == REG_RAM:
        w_rdata = r_ram[address_dmem[RAM_AW-1:0]];
      w_cyc_hit: w_rdata = r_cycle;
      w_tx_hit:  w_rdata = {24'b0, tx_data};
      w_st_hit:  w_rdata = w_status;
      default:   w_rdata = '0;
    endcase
  end

  // Old word is captured by w_rdata before this write lands.
  always_ff @(posedge clock) begin
    if (wren && w_region == REG_RAM)
      r_ram[address_dmem[RAM_AW-1:0]] <= data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_q     <= '0;
      r_cycle <= '0;
      r_ovf   <= 1'b0;
      r_berr  <= 1'b0;
    end else begin
      r_q <= w_rdata;
      if (wren && w_cyc_hit) r_cycle <= data;
      else                   r_cycle <= r_cycle + 1'b1;
      if (w_drop)
        r_ovf <= 1'b1;
      else if (wren && w_st_hit && data[ST_OVF])
        r_ovf <= 1'b0;
      if (w_region == REG_UNMAPPED)
        r_berr <= 1'b1;
      else if (wren && w_st_hit && data[ST_BERR])
        r_berr <= 1'b0;
    end
  end

  assign q_dmem  = r_q;
  assign bus_err = r_berr;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed and random checks of dmem_responder
// against a queue/array reference model.
module tb_dmem_responder;

  localparam int          DEPTH = 8;
  localparam logic [31:0] MB    = 32'h0000_1000;

  logic        clock;
  logic        reset;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        bus_err;

  dmem_responder dut (
    .clock        (clock),
    .reset        (reset),
    .address_dmem (address_dmem),
    .data         (data),
    .wren         (wren),
    .q_dmem       (q_dmem),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .bus_err      (bus_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] mram [logic [31:0]];
  logic [7:0]  fq [$];
  logic [31:0] cyc;
  logic        ovf;
  logic        berr;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got=%h exp=%h",
                tag, got, exp);
  endtask

  function automatic logic [31:0] mstat();
    int n;
    n = fq.size();
    return (n << 5) | (32'(berr) << 4)
         | (32'(ovf) << 3)
         | (32'(n == DEPTH) << 2)
         | (32'(n == 0) << 1);
  endfunction

  task automatic model_reset();
    fq.delete();
    cyc  = '0;
    ovf  = 1'b0;
    berr = 1'b0;
  endtask

  task automatic step(input logic [31:0] a,
                      input logic [31:0] d,
                      input logic        w,
                      input logic        rdy);
    logic [31:0] eq;
    bit known, pop, push, drop, st_w, unm;
    address_dmem = a;
    data         = d;
    wren         = w;
    tx_ready     = rdy;
    known = 1;
    eq    = '0;
    if (a < 32'd4096) begin
      if (mram.exists(a)) eq = mram[a];
      else known = 0;
    end else if (a == MB) eq = cyc;
    else if (a == MB + 1)
      eq = fq.size() > 0 ? {24'b0, fq[0]} : 32'd0;
    else if (a == MB + 2) eq = mstat();
    pop  = fq.size() > 0 && rdy;
    push = w && a == MB + 1;
    drop = push && fq.size() == DEPTH && !pop;
    st_w = w && a == MB + 2;
    unm  = a >= 32'd4096 && !(a >= MB && a <= MB + 2);
    if (w && a < 32'd4096) mram[a] = d;
    cyc = (w && a == MB) ? d : cyc + 1;
    if (pop) void'(fq.pop_front());
    if (push && !drop) fq.push_back(d[7:0]);
    if (drop) ovf = 1'b1;
    else if (st_w && d[3]) ovf = 1'b0;
    if (unm) berr = 1'b1;
    else if (st_w && d[4]) berr = 1'b0;
    @(posedge clock);
    @(negedge clock);
    if (known) chk("q_dmem", q_dmem, eq);
    chk("tx_valid", 32'(tx_valid),
        32'(fq.size() > 0));
    chk("tx_data", 32'(tx_data),
        fq.size() > 0 ? 32'(fq[0]) : 32'd0);
    chk("bus_err", 32'(bus_err), 32'(berr));
  endtask

  initial begin
    int r;
    logic [31:0] a;
    reset        = 1'b0;
    address_dmem = '0;
    data         = '0;
    wren         = 1'b0;
    tx_ready     = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_q", q_dmem, 32'd0);
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_txd", 32'(tx_data), 32'd0);
    chk("rst_berr", 32'(bus_err), 32'd0);
    reset = 1'b1;

    // Counter: edges 1..9 idle, edge 10 reads CYCLE
    repeat (9) step(32'd0, 32'd0, 1'b0, 1'b0);
    step(MB, 32'd0, 1'b0, 1'b0);
    chk("cyc_edge10", q_dmem, 32'd9);
    step(MB, 32'hFFFF_FFFE, 1'b1, 1'b0);
    step(MB, 32'd0, 1'b0, 1'b0);
    chk("cyc_fe", q_dmem, 32'hFFFF_FFFE);
    step(MB, 32'd0, 1'b0, 1'b0);
    chk("cyc_ff", q_dmem, 32'hFFFF_FFFF);
    step(MB, 32'd0, 1'b0, 1'b0);
    chk("cyc_wrap", q_dmem, 32'd0);

    // RAM, read-before-write
    step(32'd5, 32'h1111_1111, 1'b1, 1'b0);
    step(32'd5, 32'hDEAD_BEEF, 1'b1, 1'b0);
    chk("ram_rbw", q_dmem, 32'h1111_1111);
    step(32'd5, 32'd0, 1'b0, 1'b0);
    chk("ram_rd", q_dmem, 32'hDEAD_BEEF);

    // FIFO overflow and ordered drain
    for (int i = 0; i < 9; i++)
      step(MB + 1, 32'h41 + i, 1'b1, 1'b0);
    step(MB + 2, 32'd0, 1'b0, 1'b0);
    chk("st_full_ovf", q_dmem, 32'h10C);
    step(MB + 1, 32'd0, 1'b0, 1'b0);
    chk("tx_head", q_dmem, 32'h41);
    for (int i = 0; i < 8; i++) begin
      chk("drain_byte", 32'(tx_data), 32'h41 + i);
      step(32'd5, 32'd0, 1'b0, 1'b1);
    end
    chk("drain_empty", 32'(tx_valid), 32'd0);
    step(MB + 2, 32'd0, 1'b0, 1'b0);
    chk("st_empty", q_dmem, 32'h00A);

    // Full FIFO, push with simultaneous pop
    step(MB + 2, 32'h08, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++)
      step(MB + 1, 32'h61 + i, 1'b1, 1'b0);
    step(MB + 1, 32'h5A, 1'b1, 1'b1);
    step(MB + 2, 32'd0, 1'b0, 1'b0);
    chk("st_push_pop", q_dmem, 32'h104);
    for (int i = 0; i < 8; i++)
      step(32'd5, 32'd0, 1'b0, 1'b1);
    chk("z_last", q_dmem, 32'hDEAD_BEEF);

    // Unmapped access and clear
    step(32'h0000_2000, 32'd0, 1'b0, 1'b0);
    chk("unm_q", q_dmem, 32'd0);
    chk("unm_berr", 32'(bus_err), 32'd1);
    step(MB + 2, 32'h10, 1'b1, 1'b0);
    chk("berr_clr", 32'(bus_err), 32'd0);

    // Asynchronous reset with 3 bytes queued
    for (int i = 0; i < 3; i++)
      step(MB + 1, 32'h30 + i, 1'b1, 1'b0);
    step(MB, 32'd0, 1'b0, 1'b0);
    wren = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", 32'(tx_valid), 32'd0);
    chk("arst_q", q_dmem, 32'd0);
    chk("arst_txd", 32'(tx_data), 32'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    step(MB, 32'd0, 1'b0, 1'b0);
    chk("arst_cyc", q_dmem, 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4) a = $urandom_range(0, 15);
      else if (r == 4) a = MB;
      else if (r < 7) a = MB + 1;
      else if (r == 7) a = MB + 2;
      else if (r == 8) a = MB + 3 + $urandom_range(0, 5);
      else a = 32'h2000 + $urandom_range(0, 255);
      step(a, $urandom, 1'($urandom_range(0, 1)),
           $urandom_range(0, 2) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
